// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter_pkg
//  Purpose  : Shared types, constants and helpers for the SRAM port arbiter.
//             Holds the arbiter state encoding, default bus widths and a
//             helper that extracts one requester's slice of a flattened bus.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Widest slice and widest flattened bus that bus_slice() can handle.
    localparam int SLICE_MAX_W = 32;
    localparam int BUS_MAX_W   = 256;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_OPEN   = 1'b0;
    localparam arb_state_t ARB_LOCKED = 1'b1;

    // Returns bits [idx*width +: width] of a flattened bus, zero-extended.
    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [BUS_MAX_W-1:0] flat,
        input int                   idx,
        input int                   width
    );
        logic [BUS_MAX_W-1:0] shifted;
        shifted   = flat >> (idx * width);
        bus_slice = '0;
        for (int b = 0; b < SLICE_MAX_W; b++) begin
            if (b < width) begin
                bus_slice[b] = shifted[b];
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter_if
//  Purpose  : Bundles the requester-side and SRAM-side signals of the arbiter.
//  Ports    : req/lock/we/addr/wdata  - requester requests (flattened per id)
//             gnt/rvalid/rdata        - grants and read return to requesters
//             mem_*                   - single-port synchronous SRAM port
//  Modports : slave  - the arbiter
//             master - the requesters plus SRAM model driving the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            lock;
    logic [N_REQ-1:0]            we;
    logic [N_REQ*ADDR_WIDTH-1:0] addr;
    logic [N_REQ*DATA_WIDTH-1:0] wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]       rdata;
    logic                        mem_cs;
    logic                        mem_we;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       mem_rdata;

    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin picker. Grants the first requester
//             with req set, searching from rr_ptr upward modulo N_REQ.
//  Ports    : req    - request vector
//             rr_ptr - highest-priority requester index
//             gnt    - one-hot (or zero when req is zero) grant
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  wire  [N_REQ-1:0] req,
    input  wire  [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt
);

    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Shares one single-port synchronous SRAM (1-cycle read latency)
//             among N_REQ requesters. Round-robin per cycle, optional locked
//             bursts of up to MAX_BURST beats, read data returned one cycle
//             after issue with a per-requester valid.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - requester and SRAM signals (slave modport)
//  Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = 8
) (
    input wire                 clk,
    input wire                 rst_n,
    sram_port_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [PTR_W-1:0] r_rd_id;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rd_pend;

    logic [N_REQ-1:0]     w_pick;
    logic [N_REQ-1:0]     w_gnt;
    logic [N_REQ-1:0]     w_rvalid;
    logic [PTR_W-1:0]     w_gnt_idx;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [PTR_W-1:0]     w_owner_next;
    logic                 w_any;
    logic                 w_owner_lock;
    logic [BUS_MAX_W-1:0] w_addr_flat;
    logic [BUS_MAX_W-1:0] w_wdata_flat;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req    (bus.req),
        .rr_ptr (r_rr_ptr),
        .gnt    (w_pick)
    );

    // Grant is gated by rst_n so nothing is issued while reset is held,
    // even though the requests themselves may still be asserted.
    always_comb begin
        w_gnt = '0;
        if (rst_n) begin
            if (r_state == ARB_LOCKED) begin
                if (bus.req[r_owner]) begin
                    w_gnt[r_owner] = 1'b1;
                end
            end else begin
                w_gnt = w_pick;
            end
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = PTR_W'(k);
            end
        end
    end

    assign w_any        = |w_gnt;
    assign w_owner_lock = bus.lock[r_owner];
    assign w_next_ptr   = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_owner_next = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

    assign w_addr_flat  = BUS_MAX_W'(bus.addr);
    assign w_wdata_flat = BUS_MAX_W'(bus.wdata);

    assign bus.gnt       = w_gnt;
    assign bus.mem_cs    = w_any;
    assign bus.mem_we    = w_any & bus.we[w_gnt_idx];
    assign bus.mem_addr  = w_any ? ADDR_WIDTH'(bus_slice(w_addr_flat, int'(w_gnt_idx), ADDR_WIDTH))
                                 : '0;
    assign bus.mem_wdata = w_any ? DATA_WIDTH'(bus_slice(w_wdata_flat, int'(w_gnt_idx), DATA_WIDTH))
                                 : '0;

    always_comb begin
        w_rvalid = '0;
        if (r_rd_pend) begin
            w_rvalid[r_rd_id] = 1'b1;
        end
    end

    assign bus.rvalid = w_rvalid;
    assign bus.rdata  = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_OPEN;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_id     <= '0;
        end else begin
            r_rd_pend <= w_any & ~bus.we[w_gnt_idx];
            if (w_any) begin
                r_rd_id <= w_gnt_idx;
            end
            case (r_state)
                ARB_OPEN: begin
                    if (w_any) begin
                        r_rr_ptr <= w_next_ptr;
                        if ((MAX_BURST > 1) && bus.lock[w_gnt_idx]) begin
                            r_state     <= ARB_LOCKED;
                            r_owner     <= w_gnt_idx;
                            r_burst_cnt <= CNT_W'(1);
                        end
                    end
                end
                ARB_LOCKED: begin
                    // In this state a grant can only go to the owner, so
                    // w_any means "owner still requesting".
                    if (w_any && w_owner_lock && (r_burst_cnt < CNT_W'(MAX_BURST - 1))) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end else begin
                        // Final beat or owner dropped req: reopen arbitration
                        // with the owner's successor first in line.
                        r_state     <= ARB_OPEN;
                        r_rr_ptr    <= w_owner_next;
                        r_burst_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_OPEN;
                end
            endcase
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_gnt));
    a_rvalid_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_rvalid));
    a_cs_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n) bus.mem_cs == (|w_gnt));

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Directed self-checking bench for sram_port_arbiter with a
//             behavioural 1-cycle-latency SRAM. Unwritten SRAM locations read
//             back as {addr,addr} (e.g. addr 2 -> 0x22).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int N_REQ      = 3;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sram_port_arbiter_if #(
        .N_REQ      (N_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) bus ();

    sram_port_arbiter #(
        .N_REQ      (N_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM.
    logic [7:0]  mem     [16];
    logic [15:0] written;
    always @(posedge clk) begin
        if (!rst_n) begin
            written <= '0;
        end else if (bus.mem_cs) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr]
                                                       : {bus.mem_addr, bus.mem_addr};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks grant/chip-select and read return for the current cycle.
    task automatic chk_cycle(input string tag, input logic [2:0] exp_gnt,
                             input logic [2:0] exp_rv, input logic [7:0] exp_rd);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        chk({tag, ".cs"}, 32'(bus.mem_cs), 32'(|exp_gnt));
        chk({tag, ".rvalid"}, 32'(bus.rvalid), 32'(exp_rv));
        if (exp_rv != 3'b000) begin
            chk({tag, ".rdata"}, 32'(bus.rdata), 32'(exp_rd));
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
        @(negedge clk);
        bus.req  = r;
        bus.lock = l;
        bus.we   = w;
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        bus.req   = 3'b111;
        bus.lock  = 3'b000;
        bus.we    = 3'b000;
        bus.addr  = {4'd3, 4'd2, 4'd1};
        bus.wdata = {8'h00, 8'hA5, 8'h00};
        #2 rst_n  = 1'b0;

        // Reset with requests asserted: nothing granted or returned.
        @(negedge clk); #1;
        chk_cycle("reset", 3'b000, 3'b000, 8'h00);
        chk("reset.we", 32'(bus.mem_we), 32'd0);

        // Round robin over three readers of addresses 1/2/3.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cycle("rr0", 3'b001, 3'b000, 8'h00);
        chk("rr0.addr", 32'(bus.mem_addr), 32'd1);
        chk("rr0.we", 32'(bus.mem_we), 32'd0);
        drive(3'b111, 3'b000, 3'b000);
        chk_cycle("rr1", 3'b010, 3'b001, 8'h11);
        chk("rr1.addr", 32'(bus.mem_addr), 32'd2);
        drive(3'b111, 3'b000, 3'b000);
        chk_cycle("rr2", 3'b100, 3'b010, 8'h22);
        chk("rr2.addr", 32'(bus.mem_addr), 32'd3);
        drive(3'b111, 3'b000, 3'b000);
        chk_cycle("rr3", 3'b001, 3'b100, 8'h33);

        // Requester 1 writes 0xA5 to addr 5, then reads it back.
        bus.addr = {4'd3, 4'd5, 4'd1};
        drive(3'b010, 3'b000, 3'b010);
        chk_cycle("wr", 3'b010, 3'b001, 8'h11);
        chk("wr.we", 32'(bus.mem_we), 32'd1);
        chk("wr.addr", 32'(bus.mem_addr), 32'd5);
        chk("wr.wdata", 32'(bus.mem_wdata), 32'hA5);
        drive(3'b010, 3'b000, 3'b000);
        chk_cycle("rd5", 3'b010, 3'b000, 8'h00);
        chk("rd5.we", 32'(bus.mem_we), 32'd0);

        // Idle for 5 cycles (rr_ptr stays at 2).
        drive(3'b000, 3'b000, 3'b000);
        chk_cycle("idle0", 3'b000, 3'b010, 8'hA5);
        chk("idle0.addr", 32'(bus.mem_addr), 32'd0);
        for (int i = 1; i < 5; i++) begin
            drive(3'b000, 3'b000, 3'b000);
            chk_cycle("idle", 3'b000, 3'b000, 8'h00);
        end
        // rr_ptr=2 preserved: requester 2 wins over requester 0.
        drive(3'b101, 3'b000, 3'b000);
        chk_cycle("post_idle", 3'b100, 3'b000, 8'h00);

        // Locked burst by requester 0 with requester 2 waiting: 0,0,0,0,2,0.
        drive(3'b101, 3'b001, 3'b000);
        chk_cycle("burst0", 3'b001, 3'b100, 8'h33);
        drive(3'b101, 3'b001, 3'b000);
        chk_cycle("burst1", 3'b001, 3'b001, 8'h11);
        drive(3'b101, 3'b001, 3'b000);
        chk_cycle("burst2", 3'b001, 3'b001, 8'h11);
        drive(3'b101, 3'b001, 3'b000);
        chk_cycle("burst3", 3'b001, 3'b001, 8'h11);
        drive(3'b101, 3'b001, 3'b000);
        chk_cycle("release", 3'b100, 3'b001, 8'h11);
        drive(3'b101, 3'b001, 3'b000);
        chk_cycle("relock", 3'b001, 3'b100, 8'h33);

        // Owner 0 drops req while locked: one idle cycle.
        drive(3'b100, 3'b100, 3'b000);
        chk_cycle("drop0", 3'b000, 3'b001, 8'h11);

        // Requester 2 locks, then drops mid-burst with req[0] held.
        drive(3'b100, 3'b100, 3'b000);
        chk_cycle("lock2a", 3'b100, 3'b000, 8'h00);
        drive(3'b101, 3'b100, 3'b000);
        chk_cycle("lock2b", 3'b100, 3'b100, 8'h33);
        drive(3'b001, 3'b000, 3'b000);
        chk_cycle("drop2", 3'b000, 3'b100, 8'h33);
        // rr_ptr wrapped to 0: requester 0 beats requester 1.
        drive(3'b011, 3'b000, 3'b000);
        chk_cycle("wrap", 3'b001, 3'b000, 8'h00);

        // Read granted to requester 1, then reset while it is in flight.
        drive(3'b010, 3'b000, 3'b000);
        chk_cycle("pre_rst", 3'b010, 3'b001, 8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cycle("mid_rst", 3'b000, 3'b000, 8'h00);
        @(negedge clk); #1;
        chk_cycle("mid_rst2", 3'b000, 3'b000, 8'h00);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 3'b111;
        #1;
        chk_cycle("post_rst", 3'b001, 3'b000, 8'h00);
        drive(3'b000, 3'b000, 3'b000);
        chk_cycle("post_rst2", 3'b000, 3'b001, 8'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
